fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 64, address/PC width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 switch_branch  input  1  taken-branch redirect from the branch-control stage.
REQ-006 Flush  input  1  squash the IF/ID register contents.
REQ-007 branch_target  input  XLEN  redirect PC, sampled when switch_branch=1.
REQ-008 stall  input  1  hazard stall; hold the PC and the IF/ID register.
REQ-009 imem_req  output  1  instruction-memory request strobe.
REQ-010 imem_addr  output  XLEN  fetch address, equals the PC register.
REQ-011 imem_rdata  input  32  returned instruction word.
REQ-012 imem_valid  input  1  imem_rdata valid; may arrive in the request cycle or any later cycle.
REQ-013 if_id_pc  output  XLEN  PC of the instruction held in IF/ID.
REQ-014 if_id_instr  output  32  instruction held in IF/ID.
REQ-015 if_id_valid  output  1  IF/ID holds a live instruction.

Function
REQ-016 Three states: FETCH (imem_req=1), HOLD (imem_req=0, fetched word buffered), DISCARD (imem_req=0, stale response pending).
REQ-017 Priority per cycle: reset > switch_branch > stall > normal fetch.
REQ-018 FETCH, imem_valid=1, no redirect, stall=0: IF/ID <= {pc, imem_rdata, valid=1}; pc <= pc+4; stay FETCH.
REQ-019 FETCH, imem_valid=1, no redirect, stall=1: word and pc go to the hold buffer; pc <= pc+4; go HOLD; IF/ID unchanged.
REQ-020 FETCH, imem_valid=0, no redirect: pc and IF/ID unchanged; imem_req remains 1 with the same address.
REQ-021 HOLD, stall=0, no redirect: IF/ID <= hold buffer with valid=1; go FETCH.
REQ-022 switch_branch=1 in FETCH with imem_valid=1, or in HOLD: pc <= branch_target; the response or hold buffer is dropped; go/stay FETCH.
REQ-023 switch_branch=1 in FETCH with imem_valid=0: pc <= branch_target; go DISCARD.
REQ-024 DISCARD: imem_req=0; wait for imem_valid=1, drop that word, then go FETCH; a further switch_branch in DISCARD only reloads pc.
REQ-025 Flush=1: IF/ID <= {pc unchanged, NOP 32'h00000013, valid=0} at the next edge, overriding stall and any same-cycle IF/ID write.
REQ-026 Redirect never writes the redirected-from word into IF/ID; switch_branch with Flush=0 leaves IF/ID unchanged apart from blocking its write.
REQ-027 PC arithmetic is modulo 2^XLEN; pc+4 wraps from all-ones-minus-3 to 0 without error.
REQ-028 Throughput with single-cycle memory (imem_valid in request cycle) is one instruction per clock, IF/ID latency one edge.

Reset
REQ-029 While reset=1 at an edge: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=NOP, if_id_pc=0, hold buffer cleared.
REQ-030 During reset assertion, a concurrent imem_valid, switch_branch, Flush or stall is ignored.
REQ-031 Reset mid-request returns to FETCH (not DISCARD); the memory is required to drop outstanding requests on the same reset.

Structure
REQ-032 A shared package holds XLEN, the NOP constant 32'h00000013 and the state enumeration {FETCH, HOLD, DISCARD}.
REQ-033 The IF/ID register (load, hold, flush-to-NOP) is a single sub-module named if_id_register; PC, FSM and hold buffer stay in fetch_unit.

Verification
REQ-034 Reset release, imem_valid tied 1, imem_rdata=addr-derived -> addresses 0,4,8,12 on consecutive cycles; if_id_valid=1 from the second edge.
REQ-035 stall=1 for 3 cycles at pc=8 -> IF/ID holds pc 4, state HOLD with word@8, pc=12; after release, IF/ID=pc 8, then fetch at 12.
REQ-036 switch_branch=1, Flush=1, branch_target=0x100 at pc=0x20 -> next imem_addr=0x100, if_id_valid=0, if_id_instr=0x00000013.
REQ-037 Memory latency 3 cycles, redirect to 0x200 in cycle 1 of a request -> DISCARD until the stale word arrives, word dropped, next request at 0x200.
REQ-038 Flush=1 with stall=1 -> IF/ID cleared to NOP/valid=0 despite stall; pc unchanged.
REQ-039 reset=1 asserted in HOLD and DISCARD -> next cycle imem_addr=RESET_PC, imem_req=1, if_id_valid=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN    : default address / PC width
//   NOP     : instruction word loaded into IF/ID on flush and reset
//   state_t : fetch FSM states
package fetch_unit_pkg;

    localparam int XLEN = 64;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,  // request outstanding at pc
        HOLD    = 2'd1,  // word fetched under stall, parked in the hold buffer
        DISCARD = 2'd2   // redirected while a response was pending; drop it
    } state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
//   clk, reset          : clock, synchronous active-high reset
//   load                : capture load_pc / load_instr, set valid
//   flush               : squash to NOP with valid=0; pc is kept; beats load
//   load_pc, load_instr : incoming fetch packet
//   pc, instr, valid    : registered IF/ID contents
// With neither load nor flush asserted the contents hold, which is how a
// stall is realised.
module if_id_register
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = fetch_unit_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic            valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            instr <= NOP;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, fetch FSM, hold buffer and IF/ID.
//   clk, reset     : clock, synchronous active-high reset
//   switch_branch  : taken-branch redirect, target in branch_target
//   Flush          : squash IF/ID to NOP
//   stall          : hold PC and IF/ID
//   imem_req/addr  : request strobe and fetch address (addr is the PC)
//   imem_rdata/valid : returned word; may arrive any cycle from the request on
//   if_id_*        : IF/ID register outputs
module fetch_unit #(
    parameter int              XLEN     = fetch_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            switch_branch,
    input  logic            Flush,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid
);

    import fetch_unit_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] hold_pc, hold_pc_nxt;
    logic [31:0]     hold_instr, hold_instr_nxt;

    logic            ld;
    logic [XLEN-1:0] ld_pc;
    logic [31:0]     ld_instr;

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            hold_pc    <= '0;
            hold_instr <= NOP;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_instr <= hold_instr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_pc_nxt    = hold_pc;
        hold_instr_nxt = hold_instr;
        imem_req       = 1'b0;
        ld             = 1'b0;
        ld_pc          = pc;
        ld_instr       = imem_rdata;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (switch_branch) begin
                    // A response already here is simply dropped; one still in
                    // flight must be swallowed in DISCARD.
                    pc_nxt    = branch_target;
                    state_nxt = imem_valid ? FETCH : DISCARD;
                end else if (imem_valid) begin
                    pc_nxt = pc + PC_STEP;
                    if (stall) begin
                        // IF/ID is frozen, so park the word and stop requesting.
                        hold_pc_nxt    = pc;
                        hold_instr_nxt = imem_rdata;
                        state_nxt      = HOLD;
                    end else begin
                        ld = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (switch_branch) begin
                    pc_nxt    = branch_target;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    ld        = 1'b1;
                    ld_pc     = hold_pc;
                    ld_instr  = hold_instr;
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (switch_branch) pc_nxt = branch_target;
                if (imem_valid) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    if_id_register #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .load       (ld),
        .flush      (Flush),
        .load_pc    (ld_pc),
        .load_instr (ld_instr),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .valid      (if_id_valid)
    );

endmodule
